// File: rtl/logicnets_framer_pkg.sv
// Shared types and the sample quantiser used by the layer-0 input framer
// and by the training-side golden model.
package logicnets_framer_pkg;

  localparam int unsigned FEAT_W = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  // Three ascending thresholds split the signed range into four codes.
  function automatic logic [FEAT_W-1:0] quantise(input int sample, input int th0,
                                                 input int th1, input int th2);
    if (sample < th0)      return 2'd0;
    else if (sample < th1) return 2'd1;
    else if (sample < th2) return 2'd2;
    else                   return 2'd3;
  endfunction

endpackage

// File: rtl/logicnets_sample_quant.sv
// Combinational sample-to-code quantiser for one readout sample.
module logicnets_sample_quant
  import logicnets_framer_pkg::*;
#(
  parameter int SAMPLE_W = 12,
  parameter int TH0      = -512,
  parameter int TH1      = 0,
  parameter int TH2      = 512
) (
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic        [FEAT_W-1:0]   code
);

  always_comb code = quantise(int'(sample), TH0, TH1, TH2);

endmodule

// File: rtl/logicnets_input_framer.sv
// Packs NUM_FEAT quantised samples, aligned on in_sof, into one held
// input vector for the LogicNets layer-0 neurons.
module logicnets_input_framer #(
  parameter int SAMPLE_W = 12,
  parameter int NUM_FEAT = 3,
  parameter int FEAT_W   = 2,
  parameter int TH0      = -512,
  parameter int TH1      = 0,
  parameter int TH2      = 512
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SAMPLE_W-1:0]        in_sample,
  input  logic                       in_sof,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_FEAT*FEAT_W-1:0] out_data,
  output logic [7:0]                 sync_err_cnt
);
  import logicnets_framer_pkg::state_e;
  import logicnets_framer_pkg::IDLE;
  import logicnets_framer_pkg::FILL;

  localparam int CNT_W = $clog2(NUM_FEAT);
  localparam int VEC_W = NUM_FEAT * FEAT_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_FEAT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [VEC_W-1:0]   asm_q, asm_d;
  logic [VEC_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         err_q, err_d;
  logic [FEAT_W-1:0]  code;
  logic               accept;

  logicnets_sample_quant #(
    .SAMPLE_W (SAMPLE_W),
    .TH0      (TH0),
    .TH1      (TH1),
    .TH2      (TH2)
  ) u_quant (
    .sample (in_sample),
    .code   (code)
  );

  // Only the completing beat needs the output slot, so only it can stall.
  always_comb begin
    in_ready = !((state_q == FILL) && (count_q == LAST)) || !out_valid_q || out_ready;
    accept   = in_valid && in_ready;
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    asm_d       = asm_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (accept) begin
      if (in_sof) begin
        if (state_q == FILL) err_d = (err_q == '1) ? err_q : err_q + 8'd1;
        asm_d[FEAT_W-1:0] = code;
        count_d           = CNT_W'(1);
        state_d           = FILL;
      end else if (state_q == IDLE) begin
        err_d = (err_q == '1) ? err_q : err_q + 8'd1;
      end else begin
        for (int unsigned k = 0; k < NUM_FEAT; k++) begin
          if (count_q == CNT_W'(k)) asm_d[k*FEAT_W +: FEAT_W] = code;
        end
        // A completing beat overrides the slot release on the same edge.
        if (count_q == LAST) begin
          out_data_d  = asm_d;
          out_valid_d = 1'b1;
          count_d     = '0;
          state_d     = IDLE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign sync_err_cnt = err_q;

endmodule

// File: tb/tb_logicnets_input_framer.sv
// Self-checking bench for logicnets_input_framer: vector table, directed
// corner sequences and randomized traffic against a frame-level model.
module tb_logicnets_input_framer;
  localparam int NF = 3;
  localparam int FW = 2;
  localparam int SW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_sof, out_valid, out_ready;
  logic [SW-1:0] in_sample;
  logic [NF*FW-1:0] out_data;
  logic [7:0]    sync_err_cnt;

  int checks = 0;
  int errors = 0;

  logicnets_input_framer #(
    .SAMPLE_W (SW),
    .NUM_FEAT (NF),
    .FEAT_W   (FW),
    .TH0      (-512),
    .TH1      (0),
    .TH2      (512)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sample    (in_sample),
    .in_sof       (in_sof),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .sync_err_cnt (sync_err_cnt)
  );

  always #5 clk = ~clk;

  // Frame-level model: codes of the partial frame, the held vector, error count.
  int         part[$];
  bit         m_valid;
  logic [5:0] m_data;
  int         m_err;
  bit         cur_v, cur_sof, cur_ordy;
  int         cur_s;

  function automatic int qcode(input int s);
    if (s < -512) return 0;
    if (s < 0)    return 1;
    if (s < 512)  return 2;
    return 3;
  endfunction

  function automatic void m_reset();
    part.delete();
    m_valid = 0;
    m_data  = '0;
    m_err   = 0;
  endfunction

  function automatic bit m_ready(input bit ordy);
    return !(part.size() == NF - 1) || !m_valid || ordy;
  endfunction

  function automatic void m_bump_err();
    if (m_err < 255) m_err++;
  endfunction

  function automatic void m_step();
    bit acc;
    acc = cur_v && m_ready(cur_ordy);
    if (m_valid && cur_ordy) m_valid = 0;
    if (acc) begin
      if (cur_sof) begin
        if (part.size() > 0) m_bump_err();
        part.delete();
        part.push_back(qcode(cur_s));
      end else if (part.size() == 0) begin
        m_bump_err();
      end else begin
        part.push_back(qcode(cur_s));
        if (part.size() == NF) begin
          m_data = '0;
          for (int k = 0; k < NF; k++) m_data = m_data | (6'(part[k]) << (k * FW));
          m_valid = 1;
          part.delete();
        end
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1: apply inputs, let them settle, compare with the model.
  task automatic drive(input bit v, input bit sof, input int s, input bit ordy);
    cur_v = v; cur_sof = sof; cur_s = s; cur_ordy = ordy;
    in_valid  = v;
    in_sof    = sof;
    in_sample = SW'(s);
    out_ready = ordy;
    #2;
    chk("in_ready", int'(in_ready), int'(m_ready(ordy)));
    chk("out_valid", int'(out_valid), int'(m_valid));
    chk("out_data", int'(out_data), int'(m_data));
    chk("sync_err_cnt", int'(sync_err_cnt), m_err);
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic cycle(input bit v, input bit sof, input int s, input bit ordy);
    drive(v, sof, s, ordy);
    tick();
  endtask

  typedef struct {
    bit v; bit sof; int s; bit ordy;
    bit e_valid; logic [5:0] e_data; int e_err; bit e_ready;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1, 1, -600, 1, 0, 6'b000000, 0, 1};
    tbl[1]  = '{1, 0,  100, 1, 0, 6'b000000, 0, 1};
    tbl[2]  = '{1, 0,  700, 1, 0, 6'b000000, 0, 1};
    tbl[3]  = '{0, 0,    0, 1, 1, 6'b111000, 0, 1};
    tbl[4]  = '{1, 1, -512, 1, 0, 6'b111000, 0, 1};
    tbl[5]  = '{1, 0,    0, 1, 0, 6'b111000, 0, 1};
    tbl[6]  = '{1, 0,  511, 1, 0, 6'b111000, 0, 1};
    tbl[7]  = '{0, 0,    0, 1, 1, 6'b101001, 0, 1};
    tbl[8]  = '{1, 1,  512, 1, 0, 6'b101001, 0, 1};
    tbl[9]  = '{1, 0, -513, 1, 0, 6'b101001, 0, 1};
    tbl[10] = '{1, 0, -512, 1, 0, 6'b101001, 0, 1};
    tbl[11] = '{0, 0,    0, 1, 1, 6'b010011, 0, 1};
    tbl[12] = '{1, 0,   -1, 1, 0, 6'b010011, 0, 1};
    tbl[13] = '{1, 0,    0, 1, 0, 6'b010011, 1, 1};
    tbl[14] = '{0, 0,    0, 1, 0, 6'b010011, 2, 1};

    m_reset();
    rst_n = 1'b0; in_valid = 0; in_sof = 0; in_sample = '0; out_ready = 0;
    #12;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_err", int'(sync_err_cnt), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].sof, tbl[i].s, tbl[i].ordy);
      chk($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_data", i), int'(out_data), int'(tbl[i].e_data));
      chk($sformatf("tbl%0d_err", i), int'(sync_err_cnt), tbl[i].e_err);
      chk($sformatf("tbl%0d_ready", i), int'(in_ready), int'(tbl[i].e_ready));
      tick();
    end

    // Back-pressure: frame A held while frame B fills behind it.
    cycle(1, 1, 100, 0); cycle(1, 0, 200, 0); cycle(1, 0, 300, 0);
    drive(1, 1, -600, 0);
    chk("bp_held_valid", int'(out_valid), 1);
    chk("bp_held_data", int'(out_data), 6'b101010);
    chk("bp_b0_ready", int'(in_ready), 1);
    tick();
    drive(1, 0, 100, 0); chk("bp_b1_ready", int'(in_ready), 1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 700, 0);
      chk("bp_b2_stalled", int'(in_ready), 0);
      chk("bp_data_stable", int'(out_data), 6'b101010);
      tick();
    end
    drive(1, 0, 700, 1); chk("bp_release_ready", int'(in_ready), 1); tick();
    drive(0, 0, 0, 1);
    chk("bp_reload_valid", int'(out_valid), 1);
    chk("bp_reload_data", int'(out_data), 6'b111000);
    tick();
    drive(0, 0, 0, 0); chk("bp_drain_valid", int'(out_valid), 0); tick();

    // Abort: sof in the middle of a frame restarts it and counts one error.
    cycle(1, 1, 0, 1); cycle(1, 0, 5, 1);
    cycle(1, 1, -600, 1); cycle(1, 0, 100, 1); cycle(1, 0, 700, 1);
    drive(0, 0, 0, 1);
    chk("abort_err", int'(sync_err_cnt), 3);
    chk("abort_valid", int'(out_valid), 1);
    chk("abort_data", int'(out_data), 6'b111000);
    tick();

    // Reset with a vector held and a partial frame in progress.
    cycle(1, 1, 600, 0); cycle(1, 0, 600, 0); cycle(1, 0, 600, 0);
    cycle(1, 1, 600, 0);
    in_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_data", int'(out_data), 0);
    chk("midrst_err", int'(sync_err_cnt), 0);
    chk("midrst_ready", int'(in_ready), 1);
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(1, 0, 50, 1);
    chk("postrst_no_frame", int'(out_valid), 0);

    // Stray beats saturate the error counter.
    for (int i = 0; i < 300; i++) cycle(1, 0, int'($urandom_range(0, 2047)), 1);
    drive(0, 0, 0, 1);
    chk("sat_err", int'(sync_err_cnt), 255);
    tick();

    // Randomized traffic after a fresh reset.
    rst_n = 1'b0; #1; m_reset(); @(posedge clk); #1; rst_n = 1'b1; @(posedge clk); #1;
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
            int'($urandom_range(0, 2400)) - 1200, ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logicnets_input_framer.md
# logicnets_input_framer

Upstream feeder for the LogicNets layer-0 neuron LUTs. It accepts a stream of signed readout samples over a valid/ready handshake and quantises each sample to a FEAT_W-bit code against three thresholds. It packs NUM_FEAT consecutive codes, aligned on a start-of-frame marker, into one input vector and holds that vector stable with valid until the layer-0 wrapper accepts it. The default geometry (3 features × 2 bits) produces the 6-bit vector a layer-0 neuron consumes.

## Interface
- SAMPLE_W, 12: signed sample width.
- NUM_FEAT, 3: features per frame, ≥2.
- FEAT_W, 2: code width; fixed at 2 for the 3-threshold quantiser.
- TH0 / TH1 / TH2, -512 / 0 / 512: signed thresholds, TH0 < TH1 < TH2.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- in_sample  in  SAMPLE_W  signed sample.
- in_sof  in  1  marks the sample as feature 0 of a new frame.
- out_valid  out  1  packed vector valid.
- out_ready  in  1  downstream accept.
- out_data  out  NUM_FEAT*FEAT_W  packed codes; feature k occupies bits [k*FEAT_W +: FEAT_W].
- sync_err_cnt  out  8  saturating count of alignment errors.

## Operation
- Quantiser, combinational, signed compare: code 0 if sample < TH0; code 1 if < TH1; code 2 if < TH2; otherwise code 3.
- The frame FSM has two states.
  - IDLE: waiting for in_sof.
  - FILL: count = number of features held, 1..NUM_FEAT-1.
- IDLE, accepted beat:
  - With in_sof: store the code as feature 0, set count=1, go to FILL.
  - Without in_sof: discard the beat and increment sync_err_cnt.
  - Special case NUM_FEAT=1 is not supported.
- FILL, accepted beat without in_sof: store the code at index count and increment count.
- FILL, completing beat (count==NUM_FEAT-1): out_data ← the assembled vector including this beat, out_valid←1, count←0, go to IDLE.
- FILL, accepted beat with in_sof: abort the partial frame, increment sync_err_cnt, store the beat as feature 0, count=1, stay in FILL.
- Output slot:
  - Clears when out_valid && out_ready, unless a completing beat reloads it on the same edge, in which case out_valid stays 1 with the new data.
  - out_data does not change while out_valid && !out_ready.
- in_ready = !(state==FILL && count==NUM_FEAT-1) || !out_valid || out_ready. This is combinational from out_ready; no other path to in_ready.
  - Back-pressure therefore only ever stalls the completing beat.
  - Earlier beats of the next frame keep filling while the previous vector is held.
- sync_err_cnt saturates at 255 and never wraps.

## Timing
- Reset (async assert, sync deassert in system) sets:
  - out_valid=0, out_data=0, sync_err_cnt=0
  - state=IDLE, count=0
  - in_ready=1
- Latency: a completing beat accepted at edge t gives out_valid=1 with the full vector from the cycle after t.
- Throughput: one frame per NUM_FEAT cycles with out_ready held high; no bubbles.
- Reset mid-frame or with a vector held: the partial frame and the held vector are lost, with no error count.
- An in_sof beat that would complete a frame is impossible, since sof always restarts at index 0.

## Structure
- Package logicnets_framer_pkg contains:
  - the state enum (IDLE, FILL)
  - FEAT_W localparam
  - the quantise function shared with the training-side golden model
- One sub-module, logicnets_sample_quant: purely combinational, takes SAMPLE_W/TH0-TH2 parameters, maps sample→code.
- The framer holds the FSM, counter, assembly register, output register and error counter.

## Test plan
- Sample sequence -600(sof), 100, 700, with out_ready=1 → one cycle after the third beat, out_valid=1 and out_data=6'b11_10_00; out_valid drops the next cycle.
- Same frame with out_ready=0 for 5 cycles, next frame streamed meanwhile → first two beats of frame 2 accepted, third beat sees in_ready=0; out_data held; on out_ready=1 frame 2 is loaded on the same edge and out_valid stays high.
- Beats -1, 0 without sof from reset → both discarded, sync_err_cnt=2, out_valid stays 0.
- sof, beat, then sof again → sync_err_cnt=1; the following 3-beat frame is emitted correctly.
- Boundary values -512, 0, 511, 512 → codes 1, 2, 2, 3.
- 300 stray beats → sync_err_cnt saturates at 255; rst_n pulse mid-frame → all outputs return to reset values immediately.
